pool_argmax_stream: RTL and testbench
=====================================

# pool_argmax_stream

Streaming 2-D pooling layer with index output, successor to the fixed 2×2 max-pooling stage. It accepts one raster-ordered pixel per clock for UNITS channels (frame coordinates include blanking) and reduces each POOL×POOL non-overlapping window to one value per channel using max or average. In max mode it also emits the in-window argmax index, which the decoder-side unpooling stage consumes. The block is self-contained: it has its own line buffering and does not instantiate stream_patch. It sits between an encoder conv layer and the next layer or skip-index FIFO.

## Interface
- WIDTH, -1: active image width; hcnt < WIDTH is active.
- HEIGHT, -1: active image height; vcnt < HEIGHT is active.
- W_WIDTH, -1: frame width including blanking; W_WIDTH ≥ WIDTH + 4.
- W_HEIGHT, -1: frame height including blanking.
- FIXED_BITW, -1: bits per signed two's-complement pixel.
- UNITS, -1: number of channels.
- POOL, 2: window edge. Legal values are 2, 4 and 8.
- MODE, 0: 0 = max, 1 = average. This is a static parameter.
- clock  in  1  single clock; all logic is on the rising edge.
- n_rst  in  1  reset; synchronous, active-high (1 = reset).
- in_pixels  in  FIXED_BITW*UNITS  channel p occupies bits [p*FIXED_BITW +: FIXED_BITW].
- in_vcnt  in  log2(W_HEIGHT)  row of in_pixels.
- in_hcnt  in  log2(W_WIDTH)  column of in_pixels.
- out_pixels  out  FIXED_BITW*UNITS  pooled values, same channel packing as in_pixels.
- out_index  out  2*log2(POOL)*UNITS  per-channel argmax index = row_off*POOL + col_off.
- out_vcnt  out  log2(W_HEIGHT)  window row = in_vcnt/POOL.
- out_hcnt  out  log2(W_WIDTH)  window column = in_hcnt/POOL.
- out_valid  out  1  one-cycle strobe marking a new pooled result.

## Operation
- Window membership: the window is (in_vcnt/POOL, in_hcnt/POOL); the offset is (in_vcnt%POOL, in_hcnt%POOL). Only active pixels are used.
- Partial windows at the right and bottom edges (WIDTH or HEIGHT not a multiple of POOL) are discarded and produce no output.
- Horizontal stage, per channel: the running reduction restarts at col_off 0.
  - Max mode: a new pixel replaces the running max only if it is strictly greater (signed compare), so ties keep the earliest pixel in raster order.
  - Average mode: the stage keeps a running sum of width FIXED_BITW + 2*log2(POOL), which never overflows.
- At col_off = POOL-1 the row partial is merged into a line buffer entry indexed by in_hcnt/POOL. There are floor(WIDTH/POOL) entries per channel.
  - row_off 0 overwrites the entry.
  - Other row offsets merge with the stored entry. Max mode keeps the stored entry on ties.
- On the last pixel of a window (row_off = col_off = POOL-1) the final value is issued:
  - Max mode: the max and its index.
  - Average mode: sum >>> (2*log2(POOL)), an arithmetic shift (floor, i.e. toward −∞). out_index is 0.
- Start gating: after reset, the block ignores input until it sees in_vcnt == 0 and in_hcnt == 0. From that pixel on it is armed.
- Blanking pixels never update any state.
- When out_valid = 0, out_pixels, out_index, out_vcnt and out_hcnt hold their last values.

## Timing
- Latency: out_valid rises exactly 3 cycles after the input cycle that carries the last pixel of a window, and lasts 1 cycle.
- Throughput: one output per POOL input pixels on the last row of each window row. There is no back-pressure; input is accepted every cycle.
- Reset values: out_valid 0, out_pixels 0, out_index 0, out_vcnt 0, out_hcnt 0. The line buffer and accumulators are invalidated, and the armed flag is cleared.
- Reset mid-frame: any result still in flight is squashed, so no out_valid occurs in the 3 cycles following reset. Outputs resume in the first frame that starts after reset.
- A new frame start (in_vcnt = in_hcnt = 0) always restarts the row-0 overwrite behaviour. No state carries across frames.
- Consecutive windows on the same row produce out_valid pulses exactly POOL cycles apart.

## Test plan
Default configuration: FIXED_BITW=8, UNITS=2, WIDTH=HEIGHT=4, W_WIDTH=8, W_HEIGHT=6, POOL=2, unless a scenario states otherwise.
- Max ramp. Stimulus: ch0 = 4v+h, ch1 = −(4v+h), MODE=0. Response: 4 strobes, each 3 cycles after (1,1), (1,3), (3,1) and (3,3).
  - Window (0,0): ch0 = 5 / index 3, ch1 = 0 / index 0.
  - Window (1,1): ch0 = 15 / index 3.
- Ties. Stimulus: constant 7 on both channels. Response: every output is 7 with index 0.
- Average floor and extremes. Stimulus: MODE=1.
  - Window {−1,−2,−3,−4} → −3.
  - All 127 → 127.
  - All −128 → −128.
  - {127,127,−128,−128} → −1.
- Reset mid-frame. Stimulus: n_rst = 1 for one cycle at (2,0). Response: no out_valid for the rest of that frame. The next frame produces 4 correct results, and all outputs read 0 immediately after reset.
- Odd size. Stimulus: WIDTH=5, HEIGHT=5, ramp ch0 = 5v+h. Response: exactly 4 outputs per frame, with (0,0) = 6 / index 3. Column 4 and row 4 are ignored.
- Large window. Stimulus: POOL=4, WIDTH=HEIGHT=8, W_WIDTH=12, ch0 = 8v+h. Response: (0,0) = 27 / index 15, (1,1) = 63 / index 15, 4 strobes per frame.

Source files
------------

// File: rtl/pool_argmax_stream_if.sv
// Pixel stream bundle for pool_argmax_stream: raster input with frame
// coordinates, pooled output with per-channel argmax index and strobe.
interface pool_argmax_stream_if #(
  parameter int FIXED_BITW = 8,
  parameter int UNITS      = 2,
  parameter int POOL       = 2,
  parameter int W_WIDTH    = 8,
  parameter int W_HEIGHT   = 6
);
  localparam int VW   = $clog2(W_HEIGHT);
  localparam int HW   = $clog2(W_WIDTH);
  localparam int IDXW = 2 * $clog2(POOL);

  logic [FIXED_BITW*UNITS-1:0] in_pixels;
  logic [VW-1:0]               in_vcnt;
  logic [HW-1:0]               in_hcnt;
  logic [FIXED_BITW*UNITS-1:0] out_pixels;
  logic [IDXW*UNITS-1:0]       out_index;
  logic [VW-1:0]               out_vcnt;
  logic [HW-1:0]               out_hcnt;
  logic                        out_valid;

  modport master (
    output in_pixels, in_vcnt, in_hcnt,
    input  out_pixels, out_index, out_vcnt, out_hcnt, out_valid
  );

  modport slave (
    input  in_pixels, in_vcnt, in_hcnt,
    output out_pixels, out_index, out_vcnt, out_hcnt, out_valid
  );
endinterface

// File: rtl/pool_argmax_stream.sv
// Streaming POOLxPOOL non-overlapping pooling (max with argmax, or floor
// average) over raster pixels with blanking. Three register stages:
// input capture, horizontal reduction, line-buffer merge / output.
module pool_argmax_stream #(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4,
  parameter int W_WIDTH    = 8,
  parameter int W_HEIGHT   = 6,
  parameter int FIXED_BITW = 8,
  parameter int UNITS      = 2,
  parameter int POOL       = 2,
  parameter int MODE       = 0
) (
  input logic                 clock,
  input logic                 n_rst,
  pool_argmax_stream_if.slave bus
);
  localparam int LP   = $clog2(POOL);
  localparam int IDXW = 2 * LP;
  localparam int ACC  = FIXED_BITW + IDXW;
  localparam int LBW  = ACC + IDXW;
  localparam int VW   = $clog2(W_HEIGHT);
  localparam int HW   = $clog2(W_WIDTH);
  localparam int NWC  = WIDTH / POOL;
  localparam int NWR  = HEIGHT / POOL;
  localparam int AW   = (NWC > 1) ? $clog2(NWC) : 1;
  localparam int HLIM = NWC * POOL;
  localparam int VLIM = NWR * POOL;

  // stage 0 decode
  logic            w_start, w_armed, w_act;
  logic [LP-1:0]   w_coff, w_roff;
  logic [AW-1:0]   w_wcol;
  logic [VW-1:0]   w_wrow;

  // stage 1 registers
  logic                        r_armed;
  logic                        r1_valid;
  logic [FIXED_BITW*UNITS-1:0] r1_pix;
  logic [LP-1:0]               r1_coff, r1_roff;
  logic [AW-1:0]               r1_wcol;
  logic [VW-1:0]               r1_wrow;

  // stage 2: horizontal reduction
  logic signed [ACC-1:0] w_px   [UNITS];
  logic signed [ACC-1:0] w_hacc [UNITS];
  logic [LP-1:0]         w_hidx [UNITS];
  logic signed [ACC-1:0] r_hacc [UNITS];
  logic [LP-1:0]         r_hidx [UNITS];
  logic                  r2_valid;
  logic signed [ACC-1:0] r2_part [UNITS];
  logic [LP-1:0]         r2_pidx [UNITS];
  logic [LP-1:0]         r2_roff;
  logic [AW-1:0]         r2_wcol;
  logic [VW-1:0]         r2_wrow;

  // stage 3: vertical merge through the line buffer
  logic [LBW-1:0]        r_lb   [UNITS][1<<AW];
  logic signed [ACC-1:0] w_lbv  [UNITS];
  logic [IDXW-1:0]       w_lbi  [UNITS];
  logic signed [ACC-1:0] w_mval [UNITS];
  logic [IDXW-1:0]       w_midx [UNITS];
  logic [FIXED_BITW*UNITS-1:0] w_opix;
  logic [IDXW*UNITS-1:0]       w_oidx;

  // Decode window position; only pixels of complete windows after the first frame start count
  always_comb begin
    w_start = (bus.in_vcnt == '0) && (bus.in_hcnt == '0);
    w_armed = r_armed || w_start;
    w_act   = w_armed && (32'(bus.in_hcnt) < HLIM) && (32'(bus.in_vcnt) < VLIM);
    w_coff  = bus.in_hcnt[LP-1:0];
    w_roff  = bus.in_vcnt[LP-1:0];
    w_wcol  = AW'(bus.in_hcnt >> LP);
    w_wrow  = VW'(bus.in_vcnt >> LP);
  end

  // Capture the incoming pixel and its window coordinates
  always_ff @(posedge clock) begin
    if (n_rst) begin
      r_armed  <= 1'b0;
      r1_valid <= 1'b0;
      r1_pix   <= '0;
      r1_coff  <= '0;
      r1_roff  <= '0;
      r1_wcol  <= '0;
      r1_wrow  <= '0;
    end else begin
      r_armed  <= w_armed;
      r1_valid <= w_act;
      r1_pix   <= bus.in_pixels;
      r1_coff  <= w_coff;
      r1_roff  <= w_roff;
      r1_wcol  <= w_wcol;
      r1_wrow  <= w_wrow;
    end
  end

  // Running row reduction: restart at col_off 0, strict '>' keeps the earliest max
  always_comb begin
    for (int unsigned p = 0; p < UNITS; p++) begin
      w_px[p]   = ACC'(signed'(r1_pix[p*FIXED_BITW +: FIXED_BITW]));
      w_hacc[p] = r_hacc[p];
      w_hidx[p] = r_hidx[p];
      if (r1_coff == '0) begin
        w_hacc[p] = w_px[p];
        w_hidx[p] = '0;
      end else if (MODE == 1) begin
        w_hacc[p] = r_hacc[p] + w_px[p];
      end else if (w_px[p] > r_hacc[p]) begin
        w_hacc[p] = w_px[p];
        w_hidx[p] = r1_coff;
      end
    end
  end

  // Hold the row accumulator and hand the finished row partial to the merge stage
  always_ff @(posedge clock) begin
    if (n_rst) begin
      r2_valid <= 1'b0;
      r2_roff  <= '0;
      r2_wcol  <= '0;
      r2_wrow  <= '0;
      for (int unsigned p = 0; p < UNITS; p++) begin
        r_hacc[p]  <= '0;
        r_hidx[p]  <= '0;
        r2_part[p] <= '0;
        r2_pidx[p] <= '0;
      end
    end else begin
      r2_valid <= r1_valid && (r1_coff == '1);
      r2_roff  <= r1_roff;
      r2_wcol  <= r1_wcol;
      r2_wrow  <= r1_wrow;
      for (int unsigned p = 0; p < UNITS; p++) begin
        if (r1_valid) begin
          r_hacc[p] <= w_hacc[p];
          r_hidx[p] <= w_hidx[p];
        end
        r2_part[p] <= w_hacc[p];
        r2_pidx[p] <= w_hidx[p];
      end
    end
  end

  // Merge the row partial with the stored column entry; ties keep the stored (earlier) row
  always_comb begin
    w_opix = '0;
    w_oidx = '0;
    for (int unsigned p = 0; p < UNITS; p++) begin
      w_lbv[p]  = signed'(r_lb[p][r2_wcol][LBW-1 -: ACC]);
      w_lbi[p]  = r_lb[p][r2_wcol][IDXW-1:0];
      w_mval[p] = r2_part[p];
      w_midx[p] = {r2_roff, r2_pidx[p]};
      if (r2_roff != '0) begin
        if (MODE == 1) begin
          w_mval[p] = w_lbv[p] + r2_part[p];
        end else if (!(r2_part[p] > w_lbv[p])) begin
          w_mval[p] = w_lbv[p];
          w_midx[p] = w_lbi[p];
        end
      end
      if (MODE == 1) begin
        w_opix[p*FIXED_BITW +: FIXED_BITW] = FIXED_BITW'(w_mval[p] >>> IDXW);
        w_oidx[p*IDXW +: IDXW]             = '0;
      end else begin
        w_opix[p*FIXED_BITW +: FIXED_BITW] = FIXED_BITW'(w_mval[p]);
        w_oidx[p*IDXW +: IDXW]             = w_midx[p];
      end
    end
  end

  // Line buffer write; no reset needed since row_off 0 always overwrites before any read-merge
  always_ff @(posedge clock) begin
    if (r2_valid) begin
      for (int unsigned p = 0; p < UNITS; p++) begin
        r_lb[p][r2_wcol] <= {w_mval[p], w_midx[p]};
      end
    end
  end

  // Output register: strobe on the last row of a window, hold values otherwise
  always_ff @(posedge clock) begin
    if (n_rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_pixels <= '0;
      bus.out_index  <= '0;
      bus.out_vcnt   <= '0;
      bus.out_hcnt   <= '0;
    end else begin
      bus.out_valid <= r2_valid && (r2_roff == '1);
      if (r2_valid && (r2_roff == '1)) begin
        bus.out_pixels <= w_opix;
        bus.out_index  <= w_oidx;
        bus.out_vcnt   <= r2_wrow;
        bus.out_hcnt   <= HW'(r2_wcol);
      end
    end
  end
endmodule

// File: tb/tb_pool_argmax_stream.sv
// Scoreboard bench for pool_argmax_stream: four configurations (max, average,
// odd 5x5, POOL=4) each with a random/pattern driver, a window-level
// reference model feeding an expectation queue, and an independent monitor.
module tb_pool_argmax_stream;
  typedef struct {
    int          cyc;
    logic [15:0] pix;
    logic [15:0] idx;
    int          wr;
    int          wc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input string got, input string exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, got, exp);
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int PL   = (g == 3) ? 4 : 2;
    localparam int WD   = (g == 2) ? 5 : ((g == 3) ? 8 : 4);
    localparam int HT   = WD;
    localparam int WW   = (g == 2) ? 9 : ((g == 3) ? 12 : 8);
    localparam int WH   = (g == 2) ? 7 : ((g == 3) ? 10 : 6);
    localparam int MD   = (g == 1) ? 1 : 0;
    localparam int VW   = $clog2(WH);
    localparam int HW   = $clog2(WW);
    localparam int IDXW = 2 * $clog2(PL);
    localparam int NF   = 8;

    logic rst;
    logic signed [7:0] fr [2][WH][WW];
    exp_t q[$];

    pool_argmax_stream_if #(
      .FIXED_BITW(8), .UNITS(2), .POOL(PL), .W_WIDTH(WW), .W_HEIGHT(WH)
    ) bus ();

    pool_argmax_stream #(
      .WIDTH(WD), .HEIGHT(HT), .W_WIDTH(WW), .W_HEIGHT(WH),
      .FIXED_BITW(8), .UNITS(2), .POOL(PL), .MODE(MD)
    ) dut (
      .clock(clk),
      .n_rst(rst),
      .bus  (bus)
    );

    function automatic logic signed [7:0] patv(int f, int ch, int v, int h);
      int x, k, o;
      x = 0; k = 0; o = 0;
      case (f % 5)
        0: begin x = WD * v + h; if (ch == 1) x = -x; end
        1: x = 7;
        2: x = int'($urandom_range(0, 255)) - 128;
        3: begin
          if (PL == 2 && WD == 4 && v < 4 && h < 4) begin
            k = (v / 2) * 2 + h / 2;
            o = (v % 2) * 2 + h % 2;
            case (k)
              0: x = -1 - o;
              1: x = 127;
              2: x = -128;
              default: x = (o < 2) ? 127 : -128;
            endcase
          end else begin
            case ($urandom_range(0, 2))
              0: x = 127;
              1: x = -128;
              default: x = -1;
            endcase
          end
        end
        default: x = int'($urandom_range(0, 6)) - 3;
      endcase
      return 8'(x);
    endfunction

    task automatic push_win(int wr, int wc, int ecyc);
      exp_t e;
      int best, bi, sum, val;
      e.cyc = ecyc; e.pix = '0; e.idx = '0; e.wr = wr; e.wc = wc;
      for (int ch = 0; ch < 2; ch++) begin
        best = fr[ch][wr*PL][wc*PL];
        bi = 0;
        sum = 0;
        for (int r = 0; r < PL; r++) begin
          for (int c = 0; c < PL; c++) begin
            val = fr[ch][wr*PL+r][wc*PL+c];
            sum += val;
            if (val > best) begin best = val; bi = r * PL + c; end
          end
        end
        if (MD == 1) begin
          val = sum / (PL * PL);
          if ((sum % (PL * PL)) != 0 && sum < 0) val--;
          bi = 0;
        end else begin
          val = best;
        end
        e.pix[ch*8 +: 8]       = 8'(val);
        e.idx[ch*IDXW +: IDXW] = IDXW'(bi);
      end
      q.push_back(e);
    endtask

    initial begin : drv
      bit armed;
      armed = 1'b0;
      rst = 1'b1;
      bus.in_pixels = '0;
      bus.in_vcnt = VW'(1);
      bus.in_hcnt = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // tail of a frame already in progress: must be ignored until a frame start
      for (int v = 1; v < WH; v++) begin
        for (int h = 0; h < WW; h++) begin
          @(negedge clk);
          bus.in_vcnt = VW'(v);
          bus.in_hcnt = HW'(h);
          bus.in_pixels = 16'($urandom);
        end
      end
      for (int f = 0; f < NF; f++) begin
        for (int ch = 0; ch < 2; ch++)
          for (int v = 0; v < WH; v++)
            for (int h = 0; h < WW; h++)
              fr[ch][v][h] = patv(f, ch, v, h);
        for (int v = 0; v < WH; v++) begin
          for (int h = 0; h < WW; h++) begin
            @(negedge clk);
            bus.in_vcnt = VW'(v);
            bus.in_hcnt = HW'(h);
            bus.in_pixels = {fr[1][v][h], fr[0][v][h]};
            rst = 1'b0;
            if (g == 0 && f == 2 && v == 2 && h == 0) begin
              rst = 1'b1;
              armed = 1'b0;
              while (q.size() > 0 && q[q.size()-1].cyc >= cyc + 1) void'(q.pop_back());
            end else begin
              if (v == 0 && h == 0) armed = 1'b1;
              if (armed && (v % PL) == PL - 1 && (h % PL) == PL - 1 &&
                  v < (HT / PL) * PL && h < (WD / PL) * PL)
                push_win(v / PL, h / PL, cyc + 3);
            end
          end
        end
      end
      @(negedge clk);
      rst = 1'b0;
      bus.in_vcnt = VW'(WH - 1);
      bus.in_hcnt = HW'(WW - 1);
      repeat (8) @(negedge clk);
      chk(q.size() == 0, $sformatf("g%0d drain", g), $sformatf("%0d pending", q.size()), "0 pending");
      n_done++;
    end

    initial begin : mon
      exp_t e;
      logic [15:0] lp, li;
      int lv, lh;
      bit exp_now;
      lp = '0; li = '0; lv = 0; lh = 0;
      forever begin
        @(posedge clk);
        #1;
        if (rst) begin
          chk({bus.out_valid, bus.out_pixels, bus.out_index, bus.out_vcnt, bus.out_hcnt} == '0,
              $sformatf("g%0d reset outputs", g),
              $sformatf("v=%0b pix=%h idx=%h vc=%0d hc=%0d", bus.out_valid, bus.out_pixels,
                        bus.out_index, bus.out_vcnt, bus.out_hcnt), "all zero");
          lp = '0; li = '0; lv = 0; lh = 0;
        end else begin
          exp_now = (q.size() > 0) && (q[0].cyc == cyc);
          chk(bus.out_valid == exp_now, $sformatf("g%0d strobe @%0d", g, cyc),
              $sformatf("%0b", bus.out_valid), $sformatf("%0b", exp_now));
          if (exp_now) begin
            e = q.pop_front();
            if (bus.out_valid) begin
              chk(16'(bus.out_pixels) == e.pix && 16'(bus.out_index) == e.idx,
                  $sformatf("g%0d win(%0d,%0d) data", g, e.wr, e.wc),
                  $sformatf("pix=%h idx=%h", bus.out_pixels, bus.out_index),
                  $sformatf("pix=%h idx=%h", e.pix, e.idx));
              chk(int'(bus.out_vcnt) == e.wr && int'(bus.out_hcnt) == e.wc,
                  $sformatf("g%0d win coords", g),
                  $sformatf("(%0d,%0d)", bus.out_vcnt, bus.out_hcnt),
                  $sformatf("(%0d,%0d)", e.wr, e.wc));
              lp = e.pix; li = e.idx; lv = e.wr; lh = e.wc;
            end
          end else if (!bus.out_valid) begin
            chk(16'(bus.out_pixels) == lp && 16'(bus.out_index) == li &&
                int'(bus.out_vcnt) == lv && int'(bus.out_hcnt) == lh,
                $sformatf("g%0d hold @%0d", g, cyc),
                $sformatf("pix=%h idx=%h (%0d,%0d)", bus.out_pixels, bus.out_index,
                          bus.out_vcnt, bus.out_hcnt),
                $sformatf("pix=%h idx=%h (%0d,%0d)", lp, li, lv, lh));
          end
        end
      end
    end
  end

  initial begin : top
    int t;
    t = 0;
    while (n_done < 4 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk(n_done == 4, "completion", $sformatf("%0d configs done", n_done), "4 configs done");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
